stdcore_ser_tx: RTL and testbench
=================================

Name: stdcore_ser_tx

Overview:
Width-down serializing transmitter for the stdcore val/rdy stream protocol. It accepts one wide word of N*DW bits on a val/rdy producer port and emits it as 1..N narrow DW-bit beats on a val/rdy consumer port. It sits upstream of a stdcore registered-output FIFO, feeding its producer side. The block is fully registered on the data path, so it sustains one beat per cycle with no bubbles between words.

Parameters:
DW, 8, width of one output beat in bits
N, 4, maximum beats per input word (N>=1)
MSB_FIRST, 0, 0: beat 0 = p[DW-1:0] sent first; 1: beat 0 = p[N*DW-1:(N-1)*DW] sent first
LW, 2, width of p_len; must be >= max(1,$clog2(N))

Ports:
clk  input  1  clock; all state updates on rising edge
arst_n  input  1  asynchronous active-low reset
rst_n  input  1  synchronous active-low reset; same clear as arst_n, applied at clk edge
p  input  N*DW  wide input word
p_len  input  LW  number of valid beats minus 1 (0..N-1), sampled with p
p_val  input  1  producer valid
p_rdy  output  1  producer ready
c  output  DW  output beat (registered)
c_last  output  1  high on the final beat of a word (registered)
c_val  output  1  consumer valid (registered)
c_rdy  input  1  consumer ready

Behaviour:
- Handshake: a transfer occurs on any edge where val&&rdy, on both ports. val must not depend combinationally on rdy. Once c_val is asserted, c and c_last are held stable until c_rdy is asserted.
- State: buf (N*DW), idx (beat index), end (latched p_len), busy (c_val).
- Reset (arst_n=0 asynchronously, or rst_n=0 at an edge): busy=0, idx=0, buf=0, c=0, c_last=0, c_val=0. This gives p_rdy=1 after reset. A word in flight is discarded; there is no partial completion.
- p_rdy = !busy || (c_rdy && c_last). This is a combinational path from c_rdy to p_rdy and is intentional, to give zero-bubble back-to-back words.
- Accept (p_val&&p_rdy): buf<=p, end<=p_len, idx<=0, busy<=1. Beat 0 appears on c with c_val=1 on the next cycle, so latency is 1 cycle.
- Advance (busy && c_rdy && !c_last): idx<=idx+1, and c updates to beat idx+1 next cycle.
- Finish (busy && c_rdy && c_last):
  - If p_val is also high in the same cycle, the new word is loaded and its beat 0 is presented next cycle.
  - Otherwise busy<=0.
- c_last = (idx==end). With p_len=0, every word is a single beat and c_last=1 on it.
- p_len>N-1 is illegal. A simulation-only check must flag it; in hardware it is clamped to N-1.
- Beat selection: beat k = buf[k*DW +: DW]; when MSB_FIRST=1, k is replaced by N-1-k.
- c and c_last are driven from registers only. There is no combinational path from p to c.
- When N=1, the block degenerates to a one-entry pipeline register with c_last constantly 1 when valid.
- Throughput: one beat per cycle whenever c_rdy=1. A word of L beats occupies L cycles.

Test Plan:
(DW=8, N=4, MSB_FIRST=0 unless noted)
1. Reset and first word:
   - Stimulus: release arst_n, then present p=0x44332211, p_len=3, p_val=1, with c_rdy=1.
   - Required: p_rdy=1 at reset; c=11,22,33,44 on 4 consecutive cycles starting 1 cycle after accept; c_last only on 44; c_val=0 after.
2. Back-to-back words:
   - Stimulus: hold p_val=1 with words 0x44332211 then 0x88776655 (p_len=3), c_rdy=1.
   - Required: 8 consecutive beats 11..88 with no bubble; second accept coincides with the c_last beat 44.
3. Backpressure:
   - Stimulus: same first word; drop c_rdy for 3 cycles while c=22.
   - Required: c stays 22, c_val stays 1, p_rdy=0; sequence resumes with 33 and no beat is lost or duplicated.
4. Short words:
   - Stimulus: p_len=0 with p=0x000000AA, then p_len=1 with p=0x0000CCBB.
   - Required: beats AA(last), BB, CC(last); p_rdy high on AA's accept cycle.
5. MSB_FIRST=1:
   - Stimulus: p=0x44332211, p_len=3.
   - Required: c=44,33,22,11.
6. Reset mid-word:
   - Stimulus: assert rst_n=0 for 1 cycle while c=22 is being presented.
   - Required: next cycle c_val=0, c=0, p_rdy=1; the next word starts cleanly at its beat 0.

Source files
------------

// File: rtl/stdcore_ser_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : stdcore_ser_tx_if
//  Brief    : Wide-in / narrow-out val/rdy bundle for the serializing transmitter
//  Revision : 1.0
// ============================================================================
interface stdcore_ser_tx_if #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int LW = 2
);
    logic [N*DW-1:0] p;
    logic [LW-1:0]   p_len;
    logic            p_val;
    logic            p_rdy;
    logic [DW-1:0]   c;
    logic            c_last;
    logic            c_val;
    logic            c_rdy;

    // master: the environment that supplies words and sinks beats
    modport master (
        output p, p_len, p_val, c_rdy,
        input  p_rdy, c, c_last, c_val
    );

    modport slave (
        input  p, p_len, p_val, c_rdy,
        output p_rdy, c, c_last, c_val
    );
endinterface
`default_nettype wire

// File: rtl/stdcore_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module   : stdcore_ser_tx
//  Brief    : Width-down serializer, one N*DW word in, 1..N DW-bit beats out
//  Revision : 1.0
// ============================================================================
module stdcore_ser_tx #(
    parameter int DW        = 8,
    parameter int N         = 4,
    parameter int MSB_FIRST = 0,
    parameter int LW        = 2
) (
    input wire              clk,
    input wire              arst_n,
    input wire              rst_n,
    stdcore_ser_tx_if.slave bus
);

    localparam int            c_IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] c_LEN_MAX = LW'(N - 1);

    logic [N*DW-1:0] r_buf;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] r_end;
    logic            r_busy;
    logic [DW-1:0]   r_c;
    logic            r_last;

    logic [DW-1:0]   w_buf_beat [N];
    logic [DW-1:0]   w_p_beat   [N];
    logic [c_IW-1:0] w_len;
    logic [c_IW-1:0] w_nidx;
    logic            w_p_rdy;
    logic            w_acc;

    // Lane k of the transmit order maps to a fixed slice of the word
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int c_SEL = (MSB_FIRST != 0) ? (N - 1 - k) : k;
        assign w_buf_beat[k] = r_buf[c_SEL*DW +: DW];
        assign w_p_beat[k]   = bus.p[c_SEL*DW +: DW];
    end

    assign w_len   = (bus.p_len > c_LEN_MAX) ? c_IW'(N - 1) : bus.p_len[c_IW-1:0];
    assign w_nidx  = r_idx + c_IW'(1);
    // c_rdy feeds p_rdy directly so the next word loads on the last beat
    assign w_p_rdy = !r_busy || (bus.c_rdy && r_last);
    assign w_acc   = bus.p_val && w_p_rdy;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_end  <= '0;
            r_busy <= 1'b0;
            r_c    <= '0;
            r_last <= 1'b0;
        end else if (!rst_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_end  <= '0;
            r_busy <= 1'b0;
            r_c    <= '0;
            r_last <= 1'b0;
        end else if (w_acc) begin
            r_buf  <= bus.p;
            r_end  <= w_len;
            r_idx  <= '0;
            r_busy <= 1'b1;
            r_c    <= w_p_beat[0];
            r_last <= (w_len == '0);
        end else if (r_busy && bus.c_rdy) begin
            if (r_last) begin
                r_busy <= 1'b0;
            end else begin
                r_idx  <= w_nidx;
                r_c    <= w_buf_beat[w_nidx];
                r_last <= (w_nidx == r_end);
            end
        end
    end

    assign bus.p_rdy  = w_p_rdy;
    assign bus.c      = r_c;
    assign bus.c_last = r_last;
    assign bus.c_val  = r_busy;

    a_len_legal: assert property (@(posedge clk) disable iff (!arst_n || !rst_n)
        (bus.p_val && w_p_rdy) |-> (bus.p_len <= c_LEN_MAX));

endmodule
`default_nettype wire

// File: tb/tb_stdcore_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stdcore_ser_tx
//  Brief    : Self-checking bench, LSB-first and MSB-first instances in lockstep
//  Revision : 1.0
// ============================================================================
module tb_stdcore_ser_tx;

    logic clk;
    logic arst_n;
    logic rst_n;
    int   ncmp;
    int   nfail;

    // {last, data} of every beat still owed by each instance
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    stdcore_ser_tx_if #(.DW(8), .N(4), .LW(2)) bus0 ();
    stdcore_ser_tx_if #(.DW(8), .N(4), .LW(2)) bus1 ();

    stdcore_ser_tx #(.DW(8), .N(4), .MSB_FIRST(0), .LW(2)) u_dut0 (
        .clk    (clk),
        .arst_n (arst_n),
        .rst_n  (rst_n),
        .bus    (bus0)
    );

    stdcore_ser_tx #(.DW(8), .N(4), .MSB_FIRST(1), .LW(2)) u_dut1 (
        .clk    (clk),
        .arst_n (arst_n),
        .rst_n  (rst_n),
        .bus    (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check just after, apply the edge to the model
    task automatic step(input logic pv, input logic [31:0] w, input logic [1:0] len,
                        input logic cr, input logic rs);
        logic exp_rdy;
        logic acc;
        logic cons;
        bus0.p_val = pv;  bus1.p_val = pv;
        bus0.p     = w;   bus1.p     = w;
        bus0.p_len = len; bus1.p_len = len;
        bus0.c_rdy = cr;  bus1.c_rdy = cr;
        rst_n      = rs;
        #1;
        exp_rdy = (q0.size() == 0) || (q0.size() == 1 && cr);
        chk("c_val_lsb", 32'(bus0.c_val), 32'(q0.size() != 0));
        chk("c_val_msb", 32'(bus1.c_val), 32'(q1.size() != 0));
        if (q0.size() != 0) begin
            chk("c_lsb",    32'(bus0.c),      32'(q0[0][7:0]));
            chk("last_lsb", 32'(bus0.c_last), 32'(q0[0][8]));
        end
        if (q1.size() != 0) begin
            chk("c_msb",    32'(bus1.c),      32'(q1[0][7:0]));
            chk("last_msb", 32'(bus1.c_last), 32'(q1[0][8]));
        end
        chk("p_rdy_lsb", 32'(bus0.p_rdy), 32'(exp_rdy));
        chk("p_rdy_msb", 32'(bus1.p_rdy), 32'(exp_rdy));
        acc  = pv && exp_rdy;
        cons = (q0.size() != 0) && cr;
        @(posedge clk);
        if (!rs) begin
            q0.delete();
            q1.delete();
        end else begin
            if (cons) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (acc) begin
                for (int k = 0; k <= int'(len); k++) begin
                    q0.push_back({k == int'(len), w[k*8 +: 8]});
                    q1.push_back({k == int'(len), w[(3-k)*8 +: 8]});
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_c_val"},  32'(bus0.c_val),  32'd0);
        chk({tag, "_c"},      32'(bus0.c),      32'd0);
        chk({tag, "_c_last"}, 32'(bus0.c_last), 32'd0);
        chk({tag, "_p_rdy"},  32'(bus0.p_rdy),  32'd1);
        chk({tag, "_c_msb"},  32'(bus1.c),      32'd0);
    endtask

    initial begin
        ncmp   = 0;
        nfail  = 0;
        arst_n = 1'b0;
        rst_n  = 1'b1;
        bus0.p = '0; bus0.p_len = '0; bus0.p_val = 1'b0; bus0.c_rdy = 1'b0;
        bus1.p = '0; bus1.p_len = '0; bus1.p_val = 1'b0; bus1.c_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_cleared("arst");
        arst_n = 1'b1;

        // First word after reset, then idle
        step(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

        // Back-to-back: second word lands on the first word's last beat
        for (int i = 0; i < 4; i++) step(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

        // Backpressure while beat 22 is presented
        step(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h99999999, 2'd3, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

        // Short words
        step(1'b1, 32'h000000AA, 2'd0, 1'b1, 1'b1);
        step(1'b1, 32'h0000CCBB, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

        // Synchronous reset in the middle of a word
        step(1'b1, 32'h44332211, 2'd3, 1'b1, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
        step(1'b1, 32'h55555555, 2'd3, 1'b1, 1'b0);
        chk_cleared("srst");
        step(1'b1, 32'h88776655, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);

        // Random traffic with occasional synchronous reset
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
        chk("drained", 32'(q0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
